power_sequencer: RTL and testbench
==================================

# power_sequencer

Sequences power-down and power-up of the MIPS core's switchable domain. It consumes the `sw_ctrl_net` request produced by `power_manager` and drives the core clock enable, isolation, retention save/restore and the power-switch enable. It also handshakes with the switch chain's acknowledge. It sits between `power_manager` and the power-switch/isolation cells in `top`, and replaces the undriven `sw_enable`/`iso_enable` nets.

## Interface
- `ISO_SETUP`, 2: cycles held in ISO and DEISO; legal range ≥1.
- `SAVE_CYCLES`, 3: cycles held in SAVE and RESTORE; legal range ≥1.
- `ACK_TIMEOUT`, 8: maximum cycles spent waiting for `sw_ack` in PWR_DN/PWR_UP; legal range ≥1.
- `clk` in 1: system clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `sw_ctrl_net` in 1: power-down request level from `power_manager`. 1 = go off; 0 = stay on / wake.
- `sw_ack` in 1: switch-chain acknowledge. 1 = domain powered.
- `sw_enable` out 1: power-switch enable. 1 = switches closed.
- `iso_enable` out 1: isolation clamp enable.
- `clk_en` out 1: core clock-gate enable.
- `save` out 1: retention-register save strobe.
- `restore` out 1: retention-register restore strobe.
- `busy` out 1: asserted in every state except ON and OFF.
- `pwr_err` out 1: sticky switch-acknowledge timeout flag.
- `pwr_state` out 4: current FSM state encoding.

## Operation
- Moore FSM. All outputs are decoded from the registered state.
- A single down-counter times the ISO, SAVE, DEISO and RESTORE states and the ack waits. The counter is loaded on every state entry.
- State encodings: ON=0, CLK_OFF=1, ISO=2, SAVE=3, PWR_DN=4, OFF=5, PWR_UP=6, RESTORE=7, DEISO=8.
- Outputs per state, listed as {sw_enable, iso_enable, clk_en, save, restore}:
  - ON {1,0,1,0,0}
  - CLK_OFF {1,0,0,0,0}
  - ISO {1,1,0,0,0}
  - SAVE {1,1,0,1,0}
  - PWR_DN {0,1,0,0,0}
  - OFF {0,1,0,0,0}
  - PWR_UP {1,1,0,0,0}
  - RESTORE {1,1,0,0,1}
  - DEISO {1,0,0,0,0}
- Transitions:
  - ON: `sw_ctrl_net`=1 → CLK_OFF.
  - CLK_OFF: lasts 1 cycle. → ISO if `sw_ctrl_net`=1, else → ON (abort).
  - ISO: after ISO_SETUP cycles → SAVE. If `sw_ctrl_net`=0 in any cycle → DEISO (abort).
  - SAVE: after SAVE_CYCLES cycles → PWR_DN. If `sw_ctrl_net`=0 in any cycle → DEISO (abort; state not lost).
  - PWR_DN: this state is committed and ignores `sw_ctrl_net`.
    - `sw_ack`=0 sampled → OFF.
    - ACK_TIMEOUT cycles without `sw_ack`=0 → set `pwr_err`, → PWR_UP.
  - OFF: `sw_ctrl_net`=0 → PWR_UP.
  - PWR_UP: `sw_ack`=1 sampled → RESTORE. After ACK_TIMEOUT cycles without ack, set `pwr_err` and remain in PWR_UP waiting. Never proceed unpowered.
  - RESTORE: after SAVE_CYCLES cycles → DEISO. `sw_ctrl_net` is ignored.
  - DEISO: after ISO_SETUP cycles → ON. `sw_ctrl_net` is ignored; a re-request is serviced from ON.
- `pwr_err` is cleared only by `reset_n`.
- `sw_ctrl_net` and `sw_ack` are synchronous to `clk`. No synchronizers are used.

## Timing
- Reset (asynchronous, immediate, including mid-sequence): state ON, counter 0. Outputs: `sw_enable`=1, `iso_enable`=0, `clk_en`=1, `save`=0, `restore`=0, `busy`=0, `pwr_err`=0, `pwr_state`=0.
- Let edge E be the first edge at which `sw_ctrl_net`=1 is sampled in ON. Then:
  - CLK_OFF after E.
  - ISO after E+1.
  - SAVE after E+1+ISO_SETUP.
  - PWR_DN after E+1+ISO_SETUP+SAVE_CYCLES.
- PWR_DN → OFF occurs at the first edge that samples `sw_ack`=0. Minimum dwell in PWR_DN is 1 cycle.
- Timeout is declared at the ACK_TIMEOUT-th edge spent in the wait state. `pwr_err` rises in the same cycle the state changes.
- Let edge W be the edge at which `sw_ctrl_net`=0 is sampled in OFF. Then:
  - PWR_UP after W.
  - RESTORE after the edge sampling `sw_ack`=1.
  - DEISO after SAVE_CYCLES more cycles.
  - ON after ISO_SETUP more cycles.
- Ordering guarantees:
  - `clk_en` falls at least 1 cycle before `iso_enable` rises.
  - `iso_enable` is high in every cycle where `sw_enable`=0.
  - `clk_en` rises only after `iso_enable` has been 0 for ISO_SETUP cycles.

## Test plan
Parameters for all scenarios: ISO_SETUP=2, SAVE_CYCLES=3, ACK_TIMEOUT=8.
- Reset: assert `reset_n`=0 mid-SAVE. Required: `pwr_state`=0, `sw_enable`=1, `iso_enable`=0, `clk_en`=1 immediately, before the next edge.
- Full down: `sw_ctrl_net`=1 sampled at edge 0, model drops `sw_ack` 2 cycles after `sw_enable` falls. Required states: CLK_OFF@1, ISO@2–3, SAVE@4–6 (`save`=1), PWR_DN@7–8, OFF@9. Then `busy`=0.
- Full up: from OFF, `sw_ctrl_net`=0, `sw_ack` rises 3 cycles after `sw_enable`. Required: RESTORE for 3 cycles, DEISO for 2 cycles, then ON with `clk_en`=1 and `pwr_err`=0.
- Abort: drop `sw_ctrl_net` during the 2nd SAVE cycle. Required: DEISO for 2 cycles, then ON; `sw_enable` never falls; `restore` never asserts.
- Down timeout: hold `sw_ack`=1 throughout. Required: 8 cycles in PWR_DN, then `pwr_err`=1 and PWR_UP; `sw_ack`=1 already sampled → RESTORE next cycle.
- Up timeout: hold `sw_ack`=0 in PWR_UP. Required: `pwr_err`=1 after 8 cycles, state stays 6. Raising `sw_ack` → RESTORE; `pwr_err` stays 1.

Source files
------------

// File: rtl/power_sequencer.sv
// Power-down / power-up sequencer for the switchable MIPS core domain.
// Moore FSM with one shared down-counter timing every dwell and ack wait.
module power_sequencer #(
   parameter int ISO_SETUP   = 2,
   parameter int SAVE_CYCLES = 3,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sw_ctrl_net,
   input  logic       sw_ack,
   output logic       sw_enable,
   output logic       iso_enable,
   output logic       clk_en,
   output logic       save,
   output logic       restore,
   output logic       busy,
   output logic       pwr_err,
   output logic [3:0] pwr_state
);

   localparam int MAX_A = (ISO_SETUP > SAVE_CYCLES) ? ISO_SETUP : SAVE_CYCLES;
   localparam int MAX_C = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   typedef enum logic [3:0] {
      S_ON      = 4'd0,
      S_CLK_OFF = 4'd1,
      S_ISO     = 4'd2,
      S_SAVE    = 4'd3,
      S_PWR_DN  = 4'd4,
      S_OFF     = 4'd5,
      S_PWR_UP  = 4'd6,
      S_RESTORE = 4'd7,
      S_DEISO   = 4'd8
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_ON;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         S_ON:      if (sw_ctrl_net) state_d = S_CLK_OFF;
         S_CLK_OFF: state_d = sw_ctrl_net ? S_ISO : S_ON;
         S_ISO: begin
            if (!sw_ctrl_net)     state_d = S_DEISO;
            else if (cnt_q == '0) state_d = S_SAVE;
         end
         S_SAVE: begin
            if (!sw_ctrl_net)     state_d = S_DEISO;
            else if (cnt_q == '0) state_d = S_PWR_DN;
         end
         S_PWR_DN: begin
            if (!sw_ack) begin
               state_d = S_OFF;
            end else if (cnt_q == '0) begin
               state_d = S_PWR_UP;
               err_d   = 1'b1;
            end
         end
         S_OFF:     if (!sw_ctrl_net) state_d = S_PWR_UP;
         // Without an ack the domain is unpowered, so keep waiting forever.
         S_PWR_UP: begin
            if (sw_ack)           state_d = S_RESTORE;
            else if (cnt_q == '0) err_d   = 1'b1;
         end
         S_RESTORE: if (cnt_q == '0) state_d = S_DEISO;
         S_DEISO:   if (cnt_q == '0) state_d = S_ON;
         default:   state_d = S_ON;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         case (state_d)
            S_ISO, S_DEISO:     cnt_d = CW'(ISO_SETUP - 1);
            S_SAVE, S_RESTORE:  cnt_d = CW'(SAVE_CYCLES - 1);
            S_PWR_DN, S_PWR_UP: cnt_d = CW'(ACK_TIMEOUT - 1);
            default:            cnt_d = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_comb begin
      sw_enable  = 1'b1;
      iso_enable = 1'b0;
      clk_en     = 1'b0;
      save       = 1'b0;
      restore    = 1'b0;
      case (state_q)
         S_ON:      clk_en = 1'b1;
         S_CLK_OFF: ;
         S_ISO:     iso_enable = 1'b1;
         S_SAVE: begin
            iso_enable = 1'b1;
            save       = 1'b1;
         end
         S_PWR_DN, S_OFF: begin
            sw_enable  = 1'b0;
            iso_enable = 1'b1;
         end
         S_PWR_UP:  iso_enable = 1'b1;
         S_RESTORE: begin
            iso_enable = 1'b1;
            restore    = 1'b1;
         end
         S_DEISO:   ;
         default:   clk_en = 1'b1;
      endcase
   end

   assign busy      = (state_q != S_ON) && (state_q != S_OFF);
   assign pwr_err   = err_q;
   assign pwr_state = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer: down/up sequences, abort, reset and ack timeouts.
module tb_power_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sw_ctrl_net;
   logic       sw_ack;
   logic       sw_enable, iso_enable, clk_en, save, restore, busy, pwr_err;
   logic [3:0] pwr_state;

   int checks = 0;
   int errors = 0;

   power_sequencer #(.ISO_SETUP(2), .SAVE_CYCLES(3), .ACK_TIMEOUT(8)) dut (
      .clk(clk), .reset_n(reset_n), .sw_ctrl_net(sw_ctrl_net), .sw_ack(sw_ack),
      .sw_enable(sw_enable), .iso_enable(iso_enable), .clk_en(clk_en),
      .save(save), .restore(restore), .busy(busy), .pwr_err(pwr_err),
      .pwr_state(pwr_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {sw_enable, iso_enable, clk_en, save, restore} for each state encoding.
   function automatic logic [4:0] exp_out(input int s);
      case (s)
         0:       return 5'b10100;
         1:       return 5'b10000;
         2:       return 5'b11000;
         3:       return 5'b11010;
         4, 5:    return 5'b01000;
         6:       return 5'b11000;
         7:       return 5'b11001;
         8:       return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic chk_st(input string tag, input int s);
      chk({tag, ".state"}, 32'(pwr_state), 32'(s));
      chk({tag, ".outs"}, 32'({sw_enable, iso_enable, clk_en, save, restore}), 32'(exp_out(s)));
      chk({tag, ".busy"}, 32'(busy), 32'((s != 0) && (s != 5)));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_dn[8];
      exp_dn = '{1, 2, 2, 3, 3, 3, 4, 4};
      reset_n     = 1'b0;
      sw_ctrl_net = 1'b0;
      sw_ack      = 1'b1;
      #2;
      chk_st("rst", 0);
      chk("rst.err", 32'(pwr_err), 32'd0);
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
      chk_st("idle", 0);

      // Full down; switch chain drops ack during the 2nd PWR_DN cycle.
      sw_ctrl_net = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk_st("down", exp_dn[i]);
         if (i == 7) sw_ack = 1'b0;
      end
      cyc();
      chk_st("down.off", 5);

      // Full up; ack arrives on the 3rd PWR_UP cycle.
      sw_ctrl_net = 1'b0;
      cyc(); chk_st("up.pu1", 6);
      cyc(); chk_st("up.pu2", 6);
      cyc(); chk_st("up.pu3", 6);
      sw_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin cyc(); chk_st("up.rest", 7); end
      for (int i = 0; i < 2; i++) begin cyc(); chk_st("up.deiso", 8); end
      cyc();
      chk_st("up.on", 0);
      chk("up.err", 32'(pwr_err), 32'd0);

      // Abort during the 2nd SAVE cycle.
      sw_ctrl_net = 1'b1;
      cyc(); chk_st("ab.clkoff", 1);
      cyc(); chk_st("ab.iso1", 2);
      cyc(); chk_st("ab.iso2", 2);
      cyc(); chk_st("ab.save1", 3);
      cyc(); chk_st("ab.save2", 3);
      sw_ctrl_net = 1'b0;
      for (int i = 0; i < 2; i++) begin cyc(); chk_st("ab.deiso", 8); end
      cyc();
      chk_st("ab.on", 0);

      // Asynchronous reset mid-SAVE takes effect before the next edge.
      sw_ctrl_net = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      chk_st("rs.save", 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk_st("rs.async", 0);
      chk("rs.err", 32'(pwr_err), 32'd0);
      cyc();
      reset_n = 1'b1;

      // Down timeout: ack never drops.
      for (int i = 0; i < 7; i++) cyc();
      chk_st("dto.entry", 4);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         chk_st("dto.wait", (i < 8) ? 4 : 6);
         chk("dto.err", 32'(pwr_err), 32'(i >= 8));
      end
      sw_ctrl_net = 1'b0;
      cyc();
      chk_st("dto.rest", 7);
      for (int i = 0; i < 5; i++) cyc();
      chk_st("dto.on", 0);
      chk("dto.sticky", 32'(pwr_err), 32'd1);

      // Up timeout: after a reset, ack stays low in PWR_UP.
      reset_n = 1'b0;
      #1;
      chk("uto.clr", 32'(pwr_err), 32'd0);
      reset_n = 1'b1;
      sw_ctrl_net = 1'b1;
      for (int i = 0; i < 7; i++) cyc();
      sw_ack = 1'b0;
      cyc();
      chk_st("uto.off", 5);
      sw_ctrl_net = 1'b0;
      cyc();
      chk_st("uto.entry", 6);
      for (int i = 1; i <= 10; i++) begin
         cyc();
         chk_st("uto.wait", 6);
         chk("uto.err", 32'(pwr_err), 32'(i >= 8));
      end
      sw_ack = 1'b1;
      cyc();
      chk_st("uto.rest", 7);
      chk("uto.sticky", 32'(pwr_err), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
